// File: rtl/apb_txn_arbiter.sv
// apb_txn_arbiter: round-robin share of one APB master port between two cmd/rsp requesters,
// with a PREADY timeout bounding every ACCESS phase.
module apb_txn_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic [1:0]          cmd_valid,
  output logic [1:0]          cmd_ready,
  input  logic [1:0]          cmd_write,
  input  logic [2*ADDR_W-1:0] cmd_addr,
  input  logic [2*DATA_W-1:0] cmd_wdata,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  state_t        state;
  logic          last_grant;
  logic [TW-1:0] timer;
  logic          g;
  logic          timeout_hit;
  always_comb begin
    g           = &cmd_valid ? ~last_grant : cmd_valid[1];
    cmd_ready   = state == IDLE ? cmd_valid & (g ? 2'b10 : 2'b01) : 2'b00;
    busy        = state != IDLE;
    timeout_hit = (TIMEOUT != 0) && (timer == TLAST);
  end
  // last_grant doubles as the owner of the transfer in flight
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      timer      <= '0;
      PSEL       <= 1'b0;
      PENABLE    <= 1'b0;
      PWRITE     <= 1'b0;
      PADDR      <= '0;
      PWDATA     <= '0;
      rsp_valid  <= 2'b00;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|cmd_valid) begin
          PWRITE     <= cmd_write[g];
          PADDR      <= g ? cmd_addr[2*ADDR_W-1:ADDR_W] : cmd_addr[ADDR_W-1:0];
          PWDATA     <= g ? cmd_wdata[2*DATA_W-1:DATA_W] : cmd_wdata[DATA_W-1:0];
          last_grant <= g;
          PSEL       <= 1'b1;
          state      <= SETUP;
        end
        SETUP: begin
          PENABLE <= 1'b1;
          timer   <= '0;
          state   <= ACCESS;
        end
        ACCESS: if (PREADY) begin
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          rsp_rdata <= PWRITE ? '0 : PRDATA;
          rsp_err   <= PSLVERR;
          rsp_valid <= last_grant ? 2'b10 : 2'b01;
          state     <= RESP;
        end else begin
          timer <= &timer ? timer : timer + 1'b1;
          if (timeout_hit) begin
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            rsp_valid <= last_grant ? 2'b10 : 2'b01;
            state     <= RESP;
          end
        end
        RESP: if (rsp_ready[last_grant]) begin
          rsp_valid <= 2'b00;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
